// File: rtl/shake_io_pkg.sv
// Definitions shared by the SHAKE256 serial input and output stages.
// Keeping them in one place keeps both ends of a loopback in agreement.
package shake_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT,
    DONE
  } ser_state_t;

  localparam int IN_WIDTH_DEFAULT  = 8;
  localparam int OUT_WIDTH_DEFAULT = 256;
  localparam int LEN_WIDTH_DEFAULT = 16;

  // SHAKE domain-separation / final-bit padding bytes, shared by both ends
  localparam logic [7:0] PAD_BEGINNING = 8'h1f;
  localparam logic [7:0] PAD_ENDING    = 8'h80;

endpackage

// File: rtl/squeeze_serializer.sv
// Splits squeezed OUT_WIDTH-bit blocks into IN_WIDTH-bit packets, LSB packet first,
// stopping after exactly out_len packets and requesting new blocks as needed.
module squeeze_serializer
  import shake_io_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEFAULT,
  parameter int OUT_WIDTH = OUT_WIDTH_DEFAULT,
  parameter int LEN_WIDTH = LEN_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] out_len,
  input  logic [OUT_WIDTH-1:0] block_in,
  input  logic                 block_valid,
  output logic                 block_ready,
  output logic [IN_WIDTH-1:0]  serial_out,
  output logic                 serial_valid,
  input  logic                 serial_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int PACKETS       = OUT_WIDTH / IN_WIDTH;
  localparam int PKT_CNT_WIDTH = $clog2(PACKETS);

  ser_state_t               state;
  ser_state_t               state_nxt;
  logic [OUT_WIDTH-1:0]     shreg;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt;
  logic [LEN_WIDTH-1:0]     remaining;

  logic blk_take;
  logic pkt_take;
  logic last_pkt;
  logic blk_end;

  assign blk_take = (state == WAIT) && block_valid;
  assign pkt_take = (state == SHIFT) && serial_ready;
  assign last_pkt = (remaining == LEN_WIDTH'(1));
  assign blk_end  = (pkt_cnt == PKT_CNT_WIDTH'(PACKETS - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (out_len == '0) ? DONE : WAIT;
      WAIT:  if (block_valid) state_nxt = SHIFT;
      SHIFT: if (serial_ready) begin
        // Length exhaustion wins over block end: a partial block is simply dropped.
        if (last_pkt)     state_nxt = DONE;
        else if (blk_end) state_nxt = WAIT;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift register is reset too, so serial_out is defined from the first cycle.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      shreg     <= '0;
      pkt_cnt   <= '0;
      remaining <= '0;
    end else begin
      if (state == IDLE && start && out_len != '0) remaining <= out_len;
      if (blk_take) begin
        shreg   <= block_in;
        pkt_cnt <= '0;
      end else if (pkt_take) begin
        shreg     <= shreg >> IN_WIDTH;
        pkt_cnt   <= pkt_cnt + PKT_CNT_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  // Outputs depend on registered state only, never directly on inputs.
  always_comb begin
    block_ready  = (state == WAIT);
    serial_valid = (state == SHIFT);
    busy         = (state != IDLE);
    done         = (state == DONE);
    serial_out   = '0;
    if (state == SHIFT) serial_out = shreg[IN_WIDTH-1:0];
  end

endmodule
